// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding and key-code width math.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    // Width of a key code: enough bits to index every row/column crossing, never zero.
    function automatic int code_bits(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad matrix lines, key event outputs and FSM state for observation.
interface keypad_scanner_if
    import keypad_scanner_pkg::*;
#(
    parameter int COLS      = 4,
    parameter int ROWS      = 4,
    parameter int CODE_BITS = code_bits(ROWS, COLS)
);

    // io_col/io_row are active-low matrix lines. key_valid and key_released are one-clock
    // strobes with no backpressure (no ready); key_code is valid from key_valid and holds
    // until the next accepted press; key_held is a level between the two strobes.
    logic [COLS-1:0]      io_col;
    logic [ROWS-1:0]      io_row;
    logic [CODE_BITS-1:0] key_code;
    logic                 key_valid;
    logic                 key_held;
    logic                 key_released;
    state_t               state;

    modport master (
        output io_col,
        output key_code,
        output key_valid,
        output key_held,
        output key_released,
        output state,
        input  io_row
    );

    modport slave (
        input  io_col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_released,
        input  state,
        output io_row
    );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row returns; resets to all-ones (no key pressed).
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= '1;
            synced <= '1;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing keypad scanner with per-key debounce; reports one code per press and a release strobe.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int NUMBER_OF_COLUMNS           = 4,
    parameter int NUMBER_OF_ROWS              = 4,
    parameter int SCAN_RATE_IN_HERTZ          = 1000,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int DEBOUNCE_SCANS              = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master bus
);

    localparam int TICKS_PER_COLUMN =
        BOARD_CLOCK_FREQUENCY_IN_HZ / SCAN_RATE_IN_HERTZ / NUMBER_OF_COLUMNS;
    localparam int CODE_BITS = code_bits(NUMBER_OF_ROWS, NUMBER_OF_COLUMNS);
    localparam int TICK_BITS = (TICKS_PER_COLUMN > 1) ? $clog2(TICKS_PER_COLUMN) : 1;
    localparam int COL_BITS  = $clog2(NUMBER_OF_COLUMNS);
    localparam int ROW_BITS  = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
    localparam int CNT_BITS  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(TICKS_PER_COLUMN - 1);
    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(NUMBER_OF_COLUMNS - 1);
    localparam logic [CNT_BITS-1:0]  CNT_LAST  = CNT_BITS'(DEBOUNCE_SCANS - 1);
    localparam logic [NUMBER_OF_COLUMNS-1:0] COL_ONE = NUMBER_OF_COLUMNS'(1);

    logic [NUMBER_OF_ROWS-1:0] rows_synced;
    logic [TICK_BITS-1:0]      tick_cnt;
    logic                      tick;
    state_t                    state;
    logic [COL_BITS-1:0]       col_idx;
    logic [ROW_BITS-1:0]       cand_row;
    logic [CODE_BITS-1:0]      cand_code;
    logic [CNT_BITS-1:0]       count;

    logic                         any_low;
    logic [ROW_BITS-1:0]          low_row;
    logic [CODE_BITS-1:0]         code_next;
    logic [COL_BITS-1:0]          col_next;
    logic [NUMBER_OF_COLUMNS-1:0] strobe_next;
    logic                         cand_row_high;

    keypad_row_sync #(
        .WIDTH(NUMBER_OF_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.io_row),
        .synced(rows_synced)
    );

    // Tick marks the end of a column period, when the row lines have had time to settle.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Lowest-index low row wins when several keys share the active column.
    always_comb begin
        any_low = 1'b0;
        low_row = '0;
        for (int r = NUMBER_OF_ROWS - 1; r >= 0; r--) begin
            if (!rows_synced[r]) begin
                any_low = 1'b1;
                low_row = ROW_BITS'(r);
            end
        end
    end

    always_comb begin
        code_next     = CODE_BITS'(low_row) * CODE_BITS'(NUMBER_OF_COLUMNS) + CODE_BITS'(col_idx);
        col_next      = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
        strobe_next   = ~(COL_ONE << col_next);
        cand_row_high = rows_synced[cand_row];
    end

    assign bus.state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= SCAN;
            col_idx          <= '0;
            bus.io_col       <= ~COL_ONE;
            cand_row         <= '0;
            cand_code        <= '0;
            count            <= '0;
            bus.key_code     <= '0;
            bus.key_valid    <= 1'b0;
            bus.key_held     <= 1'b0;
            bus.key_released <= 1'b0;
        end else begin
            bus.key_valid    <= 1'b0;
            bus.key_released <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            cand_row  <= low_row;
                            cand_code <= code_next;
                            count     <= CNT_BITS'(1);
                            state     <= CONFIRM;
                        end else begin
                            col_idx    <= col_next;
                            bus.io_col <= strobe_next;
                        end
                    end
                    CONFIRM: begin
                        if (any_low && (low_row == cand_row)) begin
                            if (count == CNT_LAST) begin
                                bus.key_code  <= cand_code;
                                bus.key_valid <= 1'b1;
                                bus.key_held  <= 1'b1;
                                count         <= '0;
                                state         <= HELD;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end else begin
                            // Bounce or a different key took over: drop silently and rescan.
                            count <= '0;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (cand_row_high) begin
                            if (count == CNT_LAST) begin
                                bus.key_released <= 1'b1;
                                bus.key_held     <= 1'b0;
                                count            <= '0;
                                state            <= SCAN;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end else begin
                            count <= '0;
                        end
                    end
                    default: begin
                        count <= '0;
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed presses, and an event scoreboard.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int COLS      = 4;
    localparam int ROWS      = 4;
    localparam int CODE_BITS = code_bits(ROWS, COLS);
    localparam int EW        = CODE_BITS + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    keypad_scanner_if #(.COLS(COLS), .ROWS(ROWS), .CODE_BITS(CODE_BITS)) bus ();

    keypad_scanner #(
        .NUMBER_OF_COLUMNS          (COLS),
        .NUMBER_OF_ROWS             (ROWS),
        .SCAN_RATE_IN_HERTZ         (100),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1600),
        .DEBOUNCE_SCANS             (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is strobed.
    logic [ROWS-1:0][COLS-1:0] pressed;
    logic [ROWS-1:0]           model_rows;

    always_comb begin
        model_rows = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (pressed[r][c] && !bus.io_col[c]) model_rows[r] = 1'b0;
            end
        end
    end

    assign bus.io_row = model_rows;

    // Scoreboard entries: {1=press / 0=release, key_code}.
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic logic [COLS-1:0] strobe(input int c);
        logic [COLS-1:0] one;
        one = COLS'(1);
        return ~(one << c);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int k;
        k = 0;
        while (bus.state != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, bus.state, s);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_io_col"}, bus.io_col, 4'b1110);
        check({tag, "_key_code"}, bus.key_code, 0);
        check({tag, "_key_valid"}, bus.key_valid, 0);
        check({tag, "_key_held"}, bus.key_held, 0);
        check({tag, "_key_released"}, bus.key_released, 0);
        check({tag, "_state"}, bus.state, SCAN);
    endtask

    // Monitor: every output strobe must match the next expected event.
    always @(negedge clk) begin
        if (bus.key_valid || bus.key_released) begin
            if (bus.key_valid && bus.key_released) check("valid_and_released_same_clk", 1, 0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual=valid%0b/released%0b code=%0d required=none at %0t",
                         bus.key_valid, bus.key_released, bus.key_code, $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                checks--;
                check("key_event", {bus.key_valid, bus.key_code}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [COLS-1:0] col0;
        logic changed;

        pressed = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;

        // Idle sweep: each column active for 4 clocks in turn.
        for (int p = 1; p <= 64; p++) begin
            @(negedge clk);
            check("idle_io_col", bus.io_col, strobe((p / 4) % 4));
        end
        check("idle_key_held", bus.key_held, 0);

        // Clean press row 2 / col 1 -> code 9.
        pressed[2][1] = 1'b1;
        exp_q.push_back({1'b1, 4'd9});
        wait_cycles(200);
        check("press_held", bus.key_held, 1);
        check("press_code", bus.key_code, 9);
        pressed[2][1] = 1'b0;
        exp_q.push_back({1'b0, 4'd9});
        n = 0;
        while (!bus.key_released && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("release_seen", bus.key_released, 1);
        check("release_latency_window", (n >= 15 && n <= 20), 1);
        wait_cycles(4);
        check("release_held_low", bus.key_held, 0);
        check("release_code_holds", bus.key_code, 9);

        // Bouncing row 0 / col 3, then stable -> exactly one press, code 3.
        for (int i = 0; i < 10; i++) begin
            pressed[0][3] = ~pressed[0][3];
            wait_cycles(6);
        end
        check("bounce_no_hold", bus.key_held, 0);
        pressed[0][3] = 1'b1;
        exp_q.push_back({1'b1, 4'd3});
        wait_cycles(120);
        check("bounce_held", bus.key_held, 1);
        check("bounce_code", bus.key_code, 3);
        exp_q.push_back({1'b0, 4'd3});
        pressed[0][3] = 1'b0;
        wait_cycles(40);
        check("bounce_release_held", bus.key_held, 0);

        // Glitch: row low for two sample ticks only.
        pressed[1][2] = 1'b1;
        wait_state(CONFIRM, 40, "glitch_enter_confirm");
        wait_cycles(2);
        pressed[1][2] = 1'b0;
        wait_cycles(10);
        check("glitch_back_to_scan", bus.state, SCAN);
        check("glitch_no_hold", bus.key_held, 0);
        col0 = bus.io_col;
        changed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.io_col != col0) changed = 1'b1;
        end
        check("glitch_rotation_resumes", changed, 1);

        // Two keys in col 0 (rows 1 and 3) -> row 1 wins, code 4.
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        exp_q.push_back({1'b1, 4'd4});
        wait_cycles(100);
        check("multi_held", bus.key_held, 1);
        check("multi_code", bus.key_code, 4);
        pressed[0][2] = 1'b1;
        wait_cycles(100);
        check("second_key_ignored_code", bus.key_code, 4);
        check("second_key_ignored_held", bus.key_held, 1);
        exp_q.push_back({1'b0, 4'd4});
        exp_q.push_back({1'b1, 4'd2});
        pressed[1][0] = 1'b0;
        pressed[3][0] = 1'b0;
        wait_cycles(100);
        check("rescan_held", bus.key_held, 1);
        check("rescan_code", bus.key_code, 2);
        exp_q.push_back({1'b0, 4'd2});
        pressed[0][2] = 1'b0;
        wait_cycles(40);
        check("rescan_release_held", bus.key_held, 0);

        // Async reset mid-CONFIRM.
        pressed[2][3] = 1'b1;
        wait_state(CONFIRM, 40, "reset_confirm_enter");
        #1 rst = 1'b0;
        #1 check_reset_values("reset_mid_confirm");
        pressed = '0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(20);

        // Async reset mid-HELD: no release strobe may follow.
        pressed[2][3] = 1'b1;
        exp_q.push_back({1'b1, 4'd11});
        n = 0;
        while (!bus.key_held && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("reset_held_enter", bus.key_held, 1);
        check("reset_held_code", bus.key_code, 11);
        #1 rst = 1'b0;
        #1 check_reset_values("reset_mid_held");
        pressed = '0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(40);
        check("post_reset_idle_held", bus.key_held, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
